acc_ordered_interconnect: RTL and testbench
===========================================

// Module: acc_ordered_interconnect
// PURPOSE
// One hierarchy level of the accelerator C-channel interconnect.
// - Routes requests from NumReq requesters to NumRsp local responders, or bypasses them to the next level.
// - Guarantees per-requester in-order responses across local and bypass targets.
// - Bounds in-flight requests per requester to MaxOutstanding, tracked by a per-requester tag FIFO.
// PARAMETERS
// NumReq         2   number of requesters (and next-level bypass ports)
// NumRsp         4   number of local responders
// ReqPldWidth    64  opaque request payload width
// RspPldWidth    64  opaque response payload width
// HierAddrWidth  2   hierarchy-level address field width
// AccAddrWidth   2   local responder index field width; must satisfy 2**AccAddrWidth >= NumRsp
// HierLevel      0   level served locally
// MaxOutstanding 4   tag FIFO depth per requester; >= 1
// (derived) IdxW = idx_width(NumReq); CntW = $clog2(MaxOutstanding+1); AW = HierAddrWidth+AccAddrWidth
// PORTS
// clk_i            in   1                  clock
// rst_i            in   1                  synchronous active-high reset
// req_valid_i      in   NumReq             requester request valid
// req_ready_o      out  NumReq             requester request ready
// req_addr_i       in   NumReq*AW          {level, index} per requester
// req_pld_i        in   NumReq*ReqPldWidth request payload
// rsp_valid_o      out  NumReq             response valid to requester
// rsp_ready_i      in   NumReq             response ready from requester
// rsp_pld_o        out  NumReq*RspPldWidth response payload
// acc_req_valid_o  out  NumRsp             request valid to local responder
// acc_req_ready_i  in   NumRsp             request ready from local responder
// acc_req_pld_o    out  NumRsp*ReqPldWidth forwarded payload
// acc_req_src_o    out  NumRsp*IdxW        requester index of forwarded request
// acc_rsp_valid_i  in   NumRsp             response valid from local responder
// acc_rsp_ready_o  out  NumRsp             response ready to local responder
// acc_rsp_pld_i    in   NumRsp*RspPldWidth response payload
// acc_rsp_dst_i    in   NumRsp*IdxW        requester index of response
// next_req_valid_o out  NumReq             bypass request valid
// next_req_ready_i in   NumReq             bypass request ready
// next_req_addr_o  out  NumReq*AW          bypass address, equal to req_addr_i
// next_req_pld_o   out  NumReq*ReqPldWidth bypass payload
// next_rsp_valid_i in   NumReq             bypass response valid
// next_rsp_ready_o out  NumReq             bypass response ready
// next_rsp_pld_i   in   NumReq*RspPldWidth bypass response payload
// outstanding_o    out  NumReq*CntW        current tag FIFO occupancy
// addr_err_o       out  NumReq             sticky decode-error flag
// BEHAVIOUR
// - Reset:
//   - rst_i clears all tag FIFOs, occupancy counters, round-robin pointers and addr_err_o.
//   - All valid outputs are 0 while rst_i is high and in the first cycle after it.
//   - In-flight tags are discarded; later responses for them are never accepted, since an empty FIFO gives ready 0.
// - Decode:
//   - level = addr[AW-1:AccAddrWidth], idx = addr[AccAddrWidth-1:0].
//   - Target is BYPASS (tag NumRsp) when level != HierLevel.
//   - Target is LOCAL idx when level == HierLevel and idx < NumRsp.
//   - Otherwise it is an ERR target.
// - Request path (combinational, 0-cycle latency):
//   - Requester i is eligible only if outstanding_o[i] < MaxOutstanding, using the registered count (a pop in the same cycle does not free a slot).
//   - BYPASS: next_req_valid_o[i] = req_valid_i[i] & eligible; req_ready_o[i] = next_req_ready_i[i] & eligible.
//   - LOCAL: per responder, round-robin arbitration among eligible requesters.
//   - The grant is locked while acc_req_valid_o & !acc_req_ready_i, so payload and src stay stable until the handshake.
//   - The pointer advances past the winner on handshake only.
//   - ERR: accepted immediately (ready 1), nothing forwarded, no tag pushed, addr_err_o[i] set until reset.
//   - A successful handshake pushes the target tag into FIFO i.
// - Response path (combinational, 0-cycle latency):
//   - FIFO i head selects the only source allowed to respond to requester i: local responder j or bypass port i.
//   - acc_rsp_ready_o[j] = acc_rsp_valid_i[j] & FIFO[dst] non-empty & head[dst] == j & rsp_ready_i[dst].
//   - next_rsp_ready_o[i] = FIFO i non-empty & head == NumRsp & rsp_ready_i[i].
//   - rsp_valid_o[i] and rsp_pld_o[i] are muxed from the selected source.
//   - A response handshake pops FIFO i.
//   - Responses from non-head sources stall with ready 0 and are never dropped or reordered.
// - Simultaneous events:
//   - Push and pop on the same FIFO in one cycle leave the count unchanged.
//   - Pointers wrap modulo MaxOutstanding.
// - Illegal input: acc_rsp_dst_i >= NumReq. Ready stays 0; simulation asserts.
// TESTING
// 1. Requester 0 sends 4 requests to level 0 idx 1 with responder 1 never responding -> 4 accepted, 5th has req_ready_o[0]=0, outstanding_o[0]=4.
// 2. Requester 0 sends to idx 2, then to bypass (level 1); bypass responds first -> next_rsp_ready_o[0]=0 until responder 2's response is delivered, then bypass delivered.
// 3. Requesters 0 and 1 hold valid to idx 3 each cycle with responder ready -> grants alternate 0,1,0,1; acc_req_src_o follows.
// 4. Responder 3 holds ready low for 3 cycles while requester 1 is granted -> acc_req_pld_o and acc_req_src_o stable, no grant switch.
// 5. NumRsp=3, request to level 0 idx 3 -> accepted in 1 cycle, no forward, addr_err_o[0]=1 and stays 1.
// 6. rst_i asserted with 2 outstanding, then responder responds -> acc_rsp_ready_o=0, outstanding_o=0, no rsp_valid_o.

Source files
------------

// File: rtl/acc_ordered_interconnect.sv
// acc_ordered_interconnect: one hierarchy level of the accelerator C-channel
// interconnect. Requests go to a local responder (round-robin per responder)
// or bypass to the next level. Each requester owns a tag FIFO recording the
// target of every accepted request, so its responses come back in request order.
module acc_ordered_interconnect #(
  parameter int NumReq         = 2,
  parameter int NumRsp         = 4,
  parameter int ReqPldWidth    = 64,
  parameter int RspPldWidth    = 64,
  parameter int HierAddrWidth  = 2,
  parameter int AccAddrWidth   = 2,
  parameter int HierLevel      = 0,
  parameter int MaxOutstanding = 4,
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntW = $clog2(MaxOutstanding + 1),
  localparam int AW   = HierAddrWidth + AccAddrWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AW-1:0]          req_addr_i,
  input  logic [NumReq*ReqPldWidth-1:0] req_pld_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [NumReq*RspPldWidth-1:0] rsp_pld_o,
  output logic [NumRsp-1:0]             acc_req_valid_o,
  input  logic [NumRsp-1:0]             acc_req_ready_i,
  output logic [NumRsp*ReqPldWidth-1:0] acc_req_pld_o,
  output logic [NumRsp*IdxW-1:0]        acc_req_src_o,
  input  logic [NumRsp-1:0]             acc_rsp_valid_i,
  output logic [NumRsp-1:0]             acc_rsp_ready_o,
  input  logic [NumRsp*RspPldWidth-1:0] acc_rsp_pld_i,
  input  logic [NumRsp*IdxW-1:0]        acc_rsp_dst_i,
  output logic [NumReq-1:0]             next_req_valid_o,
  input  logic [NumReq-1:0]             next_req_ready_i,
  output logic [NumReq*AW-1:0]          next_req_addr_o,
  output logic [NumReq*ReqPldWidth-1:0] next_req_pld_o,
  input  logic [NumReq-1:0]             next_rsp_valid_i,
  output logic [NumReq-1:0]             next_rsp_ready_o,
  input  logic [NumReq*RspPldWidth-1:0] next_rsp_pld_i,
  output logic [NumReq*CntW-1:0]        outstanding_o,
  output logic [NumReq-1:0]             addr_err_o
);

  localparam int TagW = $clog2(NumRsp + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [TagW-1:0] TagBypass = TagW'(NumRsp);

  typedef enum logic [1:0] {TGT_LOCAL, TGT_BYPASS, TGT_ERR} tgt_e;

  logic                rst_q;
  logic                active;
  tgt_e                kind     [NumReq];
  logic [TagW-1:0]     tag      [NumReq];
  logic [TagW-1:0]     head     [NumReq];
  logic [NumReq-1:0]   eligible, push, pop, err_set, err_q, err_d;
  logic [NumReq-1:0]   cand     [NumRsp];
  logic [CntW-1:0]     cnt_q    [NumReq];
  logic [CntW-1:0]     cnt_d    [NumReq];
  logic [PtrW-1:0]     wr_q     [NumReq];
  logic [PtrW-1:0]     wr_d     [NumReq];
  logic [PtrW-1:0]     rd_q     [NumReq];
  logic [PtrW-1:0]     rd_d     [NumReq];
  logic [TagW-1:0]     fifo_q   [NumReq][MaxOutstanding];
  logic [NumRsp-1:0]   lock_q, lock_d, gnt_vld;
  logic [IdxW-1:0]     gnt_idx    [NumRsp];
  logic [IdxW-1:0]     rr_q       [NumRsp];
  logic [IdxW-1:0]     rr_d       [NumRsp];
  logic [IdxW-1:0]     lock_idx_q [NumRsp];
  logic [IdxW-1:0]     lock_idx_d [NumRsp];

  // Outputs stay quiet during reset and for one cycle after it.
  assign active          = !rst_i && !rst_q;
  assign next_req_addr_o = req_addr_i;
  assign next_req_pld_o  = req_pld_i;
  assign addr_err_o      = err_q;

  // Decode each request into a target class and tag; compute eligibility and per-responder candidates.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    for (int i = 0; i < NumReq; i++) begin
      kind[i] = TGT_ERR;
      tag[i]  = '0;
      if (int'(req_addr_i[i*AW+AccAddrWidth +: HierAddrWidth]) != HierLevel) begin
        kind[i] = TGT_BYPASS;
        tag[i]  = TagBypass;
      end else if (int'(req_addr_i[i*AW +: AccAddrWidth]) < NumRsp) begin
        kind[i] = TGT_LOCAL;
        tag[i]  = TagW'(req_addr_i[i*AW +: AccAddrWidth]);
      end
      // The registered count decides; a same-cycle pop does not free a slot.
      eligible[i] = active && (cnt_q[i] < CntW'(MaxOutstanding));
      head[i]     = fifo_q[i][rd_q[i]];
    end
    for (int j = 0; j < NumRsp; j++) begin
      for (int i = 0; i < NumReq; i++) begin
        cand[j][i] = req_valid_i[i] && eligible[i] && (kind[i] == TGT_LOCAL) && (tag[i] == TagW'(j));
      end
    end
  end

  // Round-robin grant per local responder; a stalled grant stays locked until its handshake.
  always_comb begin
    int c;
    c = 0;
    for (int j = 0; j < NumRsp; j++) begin
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = '0;
      if (lock_q[j]) begin
        gnt_idx[j] = lock_idx_q[j];
        gnt_vld[j] = cand[j][lock_idx_q[j]];
      end else begin
        for (int k = 0; k < NumReq; k++) begin
          c = (int'(rr_q[j]) + k) % NumReq;
          if (!gnt_vld[j] && cand[j][c]) begin
            gnt_vld[j] = 1'b1;
            gnt_idx[j] = IdxW'(c);
          end
        end
      end
      acc_req_valid_o[j]                         = gnt_vld[j];
      acc_req_src_o[j*IdxW +: IdxW]              = gnt_idx[j];
      acc_req_pld_o[j*ReqPldWidth +: ReqPldWidth] = req_pld_i[int'(gnt_idx[j])*ReqPldWidth +: ReqPldWidth];
    end
  end

  // Request-side ready/valid per requester, plus push and error-set strobes.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      next_req_valid_o[i] = req_valid_i[i] && eligible[i] && (kind[i] == TGT_BYPASS);
      req_ready_o[i]      = 1'b0;
      unique case (kind[i])
        TGT_BYPASS: req_ready_o[i] = next_req_ready_i[i] && eligible[i];
        TGT_LOCAL: begin
          for (int j = 0; j < NumRsp; j++) begin
            if (tag[i] == TagW'(j)) begin
              req_ready_o[i] = gnt_vld[j] && (gnt_idx[j] == IdxW'(i)) && acc_req_ready_i[j];
            end
          end
        end
        default: req_ready_o[i] = active;
      endcase
      push[i]    = req_valid_i[i] && req_ready_o[i] && (kind[i] != TGT_ERR);
      err_set[i] = req_valid_i[i] && req_ready_o[i] && (kind[i] == TGT_ERR);
    end
  end

  // Response steering: only the source named by the FIFO head may respond to each requester.
  always_comb begin
    logic dst_ok;
    dst_ok           = 1'b0;
    rsp_valid_o      = '0;
    rsp_pld_o        = '0;
    next_rsp_ready_o = '0;
    acc_rsp_ready_o  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (active && (cnt_q[i] != '0)) begin
        if (head[i] == TagBypass) begin
          rsp_valid_o[i]                         = next_rsp_valid_i[i];
          rsp_pld_o[i*RspPldWidth +: RspPldWidth] = next_rsp_pld_i[i*RspPldWidth +: RspPldWidth];
          next_rsp_ready_o[i]                    = rsp_ready_i[i];
        end else begin
          for (int j = 0; j < NumRsp; j++) begin
            if (head[i] == TagW'(j)) begin
              dst_ok                                 = (acc_rsp_dst_i[j*IdxW +: IdxW] == IdxW'(i));
              rsp_valid_o[i]                         = acc_rsp_valid_i[j] && dst_ok;
              rsp_pld_o[i*RspPldWidth +: RspPldWidth] = acc_rsp_pld_i[j*RspPldWidth +: RspPldWidth];
              acc_rsp_ready_o[j]                     = acc_rsp_ready_o[j] | (acc_rsp_valid_i[j] && dst_ok && rsp_ready_i[i]);
            end
          end
        end
      end
      pop[i] = rsp_valid_o[i] && rsp_ready_i[i];
    end
  end

  // Next-state for FIFO pointers/counts, arbitration pointers, locks and error flags.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      if (push[i]) wr_d[i] = (wr_q[i] == PtrW'(MaxOutstanding - 1)) ? '0 : wr_q[i] + 1'b1;
      if (pop[i])  rd_d[i] = (rd_q[i] == PtrW'(MaxOutstanding - 1)) ? '0 : rd_q[i] + 1'b1;
      cnt_d[i] = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      outstanding_o[i*CntW +: CntW] = cnt_q[i];
    end
    err_d = err_q | err_set;
    for (int j = 0; j < NumRsp; j++) begin
      lock_d[j]     = gnt_vld[j] && !acc_req_ready_i[j];
      lock_idx_d[j] = gnt_idx[j];
      rr_d[j]       = rr_q[j];
      if (gnt_vld[j] && acc_req_ready_i[j]) rr_d[j] = IdxW'((int'(gnt_idx[j]) + 1) % NumReq);
    end
  end

  // Tag storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the tag array is left unreset; the occupancy count alone marks which entries are live.
    for (int i = 0; i < NumReq; i++) begin
      if (push[i]) fifo_q[i][wr_q[i]] <= tag[i];
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      rst_q  <= 1'b1;
      err_q  <= '0;
      lock_q <= '0;
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      for (int j = 0; j < NumRsp; j++) begin
        rr_q[j]       <= '0;
        lock_idx_q[j] <= '0;
      end
    end else begin
      rst_q  <= 1'b0;
      err_q  <= err_d;
      lock_q <= lock_d;
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= cnt_d[i];
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
      end
      for (int j = 0; j < NumRsp; j++) begin
        rr_q[j]       <= rr_d[j];
        lock_idx_q[j] <= lock_idx_d[j];
      end
    end
  end

  // A local response addressed to a nonexistent requester is an integration error.
  for (genvar j = 0; j < NumRsp; j++) begin : g_dst_chk
    a_dst_range: assert property (@(posedge clk_i) disable iff (rst_i)
      acc_rsp_valid_i[j] |-> (int'(acc_rsp_dst_i[j*IdxW +: IdxW]) < NumReq));
  end

endmodule

// File: tb/tb_acc_ordered_interconnect.sv
// Directed bench for acc_ordered_interconnect with NumRsp=3 so that local
// index 3 decodes as an address error.
module tb_acc_ordered_interconnect;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   req_valid_i, req_ready_o;
  logic [7:0]   req_addr_i;
  logic [127:0] req_pld_i;
  logic [1:0]   rsp_valid_o, rsp_ready_i;
  logic [127:0] rsp_pld_o;
  logic [2:0]   acc_req_valid_o, acc_req_ready_i;
  logic [191:0] acc_req_pld_o;
  logic [2:0]   acc_req_src_o;
  logic [2:0]   acc_rsp_valid_i, acc_rsp_ready_o;
  logic [191:0] acc_rsp_pld_i;
  logic [2:0]   acc_rsp_dst_i;
  logic [1:0]   next_req_valid_o, next_req_ready_i;
  logic [7:0]   next_req_addr_o;
  logic [127:0] next_req_pld_o;
  logic [1:0]   next_rsp_valid_i, next_rsp_ready_o;
  logic [127:0] next_rsp_pld_i;
  logic [5:0]   outstanding_o;
  logic [1:0]   addr_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  acc_ordered_interconnect #(.NumReq(2), .NumRsp(3), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i), .req_pld_i(req_pld_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_pld_o(rsp_pld_o),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_pld_o(acc_req_pld_o), .acc_req_src_o(acc_req_src_o),
    .acc_rsp_valid_i(acc_rsp_valid_i), .acc_rsp_ready_o(acc_rsp_ready_o),
    .acc_rsp_pld_i(acc_rsp_pld_i), .acc_rsp_dst_i(acc_rsp_dst_i),
    .next_req_valid_o(next_req_valid_o), .next_req_ready_i(next_req_ready_i),
    .next_req_addr_o(next_req_addr_o), .next_req_pld_o(next_req_pld_o),
    .next_rsp_valid_i(next_rsp_valid_i), .next_rsp_ready_o(next_rsp_ready_o),
    .next_rsp_pld_i(next_rsp_pld_i),
    .outstanding_o(outstanding_o), .addr_err_o(addr_err_o)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i            = 1'b1;
    req_valid_i      = 2'b11;
    req_addr_i       = {4'b0100, 4'b0100};
    req_pld_i        = '0;
    rsp_ready_i      = 2'b11;
    acc_req_ready_i  = '0;
    acc_rsp_valid_i  = '0;
    acc_rsp_pld_i    = '0;
    acc_rsp_dst_i    = '0;
    next_req_ready_i = 2'b11;
    next_rsp_valid_i = '0;
    next_rsp_pld_i   = '0;

    // Reset: no valids while high or in the first cycle after.
    tick(); #1;
    check("rst_next_req_valid", 64'(next_req_valid_o), 64'h0);
    check("rst_outstanding", 64'(outstanding_o), 64'h0);
    check("rst_addr_err", 64'(addr_err_o), 64'h0);
    tick(); rst_i = 1'b0; #1;
    check("post_rst_next_req_valid", 64'(next_req_valid_o), 64'h0);
    check("post_rst_req_ready", 64'(req_ready_o), 64'h0);
    tick(); #1;
    check("active_next_req_valid", 64'(next_req_valid_o), 64'h3);
    req_valid_i = 2'b00;

    // Test 1: four requests to idx 1 fill the tag FIFO.
    tick();
    req_valid_i = 2'b01; req_addr_i = {4'b0000, 4'b0001}; req_pld_i = {64'h0, 64'hA0};
    acc_req_ready_i = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fill_req_ready", 64'(req_ready_o[0]), 64'h1);
      check("fill_acc_valid", 64'(acc_req_valid_o), 64'h2);
      check("fill_outstanding", 64'(outstanding_o[2:0]), 64'(k));
      tick();
    end
    #1;
    check("full_req_ready", 64'(req_ready_o[0]), 64'h0);
    check("full_acc_valid", 64'(acc_req_valid_o), 64'h0);
    check("full_outstanding", 64'(outstanding_o[2:0]), 64'h4);
    // Pop while full: the registered count still blocks the new request.
    acc_rsp_valid_i = 3'b010; acc_rsp_dst_i = 3'b000; acc_rsp_pld_i[127:64] = 64'hD1;
    #1;
    check("full_pop_rsp_valid", 64'(rsp_valid_o), 64'h1);
    check("full_pop_rsp_pld", rsp_pld_o[63:0], 64'hD1);
    check("full_pop_acc_rsp_ready", 64'(acc_rsp_ready_o), 64'h2);
    check("full_pop_req_ready", 64'(req_ready_o[0]), 64'h0);
    tick(); #1;
    check("after_pop_outstanding", 64'(outstanding_o[2:0]), 64'h3);
    check("push_pop_req_ready", 64'(req_ready_o[0]), 64'h1);
    check("push_pop_rsp_valid", 64'(rsp_valid_o[0]), 64'h1);
    tick(); #1;
    check("push_pop_outstanding", 64'(outstanding_o[2:0]), 64'h3);
    req_valid_i = 2'b00; acc_rsp_valid_i = 3'b000;

    // Test 6: reset with tags in flight; a late response is refused.
    tick();
    rst_i = 1'b1; acc_rsp_valid_i = 3'b010; #1;
    check("in_rst_acc_rsp_ready", 64'(acc_rsp_ready_o), 64'h0);
    check("in_rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    tick(); #1;
    check("in_rst_outstanding", 64'(outstanding_o), 64'h0);
    rst_i = 1'b0;
    tick(); #1;
    check("post_rst_acc_rsp_ready", 64'(acc_rsp_ready_o), 64'h0);
    tick(); #1;
    check("late_acc_rsp_ready", 64'(acc_rsp_ready_o), 64'h0);
    check("late_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("late_outstanding", 64'(outstanding_o), 64'h0);
    acc_rsp_valid_i = 3'b000;

    // Test 2: local idx 2 then bypass; bypass response waits its turn.
    tick();
    req_valid_i = 2'b01; req_addr_i = {4'b0000, 4'b0010}; acc_req_ready_i = 3'b100;
    next_req_ready_i = 2'b01; req_pld_i = {64'h0, 64'hC0DE};
    #1;
    check("ord_local_ready", 64'(req_ready_o[0]), 64'h1);
    check("ord_local_pld", acc_req_pld_o[191:128], 64'hC0DE);
    tick();
    req_addr_i = {4'b0000, 4'b0100}; #1;
    check("ord_bypass_valid", 64'(next_req_valid_o), 64'h1);
    check("ord_bypass_addr", 64'(next_req_addr_o[3:0]), 64'h4);
    check("ord_bypass_pld", next_req_pld_o[63:0], 64'hC0DE);
    check("ord_bypass_no_local", 64'(acc_req_valid_o), 64'h0);
    tick();
    req_valid_i = 2'b00;
    next_rsp_valid_i = 2'b01; next_rsp_pld_i = {64'h0, 64'hB0B0}; #1;
    check("ord_outstanding", 64'(outstanding_o[2:0]), 64'h2);
    check("ord_bypass_stalled", 64'(next_rsp_ready_o), 64'h0);
    check("ord_no_rsp_yet", 64'(rsp_valid_o), 64'h0);
    tick();
    acc_rsp_valid_i = 3'b100; acc_rsp_dst_i = 3'b000; acc_rsp_pld_i[191:128] = 64'hC2C2; #1;
    check("ord_local_rsp_valid", 64'(rsp_valid_o), 64'h1);
    check("ord_local_rsp_pld", rsp_pld_o[63:0], 64'hC2C2);
    check("ord_local_acc_ready", 64'(acc_rsp_ready_o), 64'h4);
    check("ord_bypass_still_stalled", 64'(next_rsp_ready_o), 64'h0);
    tick();
    acc_rsp_valid_i = 3'b000; #1;
    check("ord_bypass_ready", 64'(next_rsp_ready_o), 64'h1);
    check("ord_bypass_rsp_pld", rsp_pld_o[63:0], 64'hB0B0);
    tick();
    next_rsp_valid_i = 2'b00; #1;
    check("ord_drained", 64'(outstanding_o), 64'h0);

    // Test 3: both requesters to idx 0, grants alternate.
    tick();
    req_valid_i = 2'b11; req_addr_i = {4'b0000, 4'b0000}; acc_req_ready_i = 3'b001;
    req_pld_i = {64'hE1, 64'hE0};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_src", 64'(acc_req_src_o[0]), 64'(k % 2));
      check("rr_req_ready", 64'(req_ready_o), (k % 2 == 1) ? 64'h2 : 64'h1);
      check("rr_pld", acc_req_pld_o[63:0], (k % 2 == 1) ? 64'hE1 : 64'hE0);
      tick();
    end
    req_valid_i = 2'b00;

    // Test 4: a stalled grant to requester 1 stays locked.
    req_valid_i = 2'b10; req_addr_i = {4'b0001, 4'b0001}; acc_req_ready_i = 3'b000;
    req_pld_i = {64'hF1, 64'hF0}; #1;
    check("lock_first_src", 64'(acc_req_src_o[1]), 64'h1);
    check("lock_first_valid", 64'(acc_req_valid_o), 64'h2);
    tick();
    req_valid_i = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("lock_src", 64'(acc_req_src_o[1]), 64'h1);
      check("lock_pld", acc_req_pld_o[127:64], 64'hF1);
      check("lock_req_ready", 64'(req_ready_o), 64'h0);
      tick();
    end
    acc_req_ready_i = 3'b010; #1;
    check("lock_release_ready", 64'(req_ready_o), 64'h2);
    tick(); #1;
    check("lock_next_src", 64'(acc_req_src_o[1]), 64'h0);
    check("lock_next_ready", 64'(req_ready_o), 64'h1);
    tick();
    req_valid_i = 2'b00; #1;
    check("lock_outstanding", 64'(outstanding_o), 64'o33);

    // Test 5: idx 3 with NumRsp=3 is a decode error.
    tick();
    req_valid_i = 2'b01; req_addr_i = {4'b0000, 4'b0011}; #1;
    check("err_ready", 64'(req_ready_o[0]), 64'h1);
    check("err_no_local", 64'(acc_req_valid_o), 64'h0);
    check("err_no_bypass", 64'(next_req_valid_o), 64'h0);
    check("err_flag_before", 64'(addr_err_o), 64'h0);
    tick();
    req_valid_i = 2'b00; #1;
    check("err_flag_set", 64'(addr_err_o), 64'h1);
    check("err_no_push", 64'(outstanding_o), 64'o33);
    tick(); tick(); #1;
    check("err_flag_sticky", 64'(addr_err_o), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
